// File: rtl/vb_pkg.sv
// rtl/vb_pkg.sv - shared variable-byte constants and FSM state enum (VBEncoder/vb_decoder)
package vb_pkg;
   localparam int VB_MAX_BYTES = 5;
   localparam int VB_CONT_BIT  = 7;
   localparam int VB_PAYLOAD_W = 7;

   typedef enum logic [1:0] {
      VB_ACCUM = 2'd0,
      VB_HOLD  = 2'd1,
      VB_DRAIN = 2'd2
   } vb_state_e;
endpackage

// File: rtl/vb_accum.sv
// rtl/vb_accum.sv - payload insert datapath: places a 7-bit group at its index, flags group-4 overflow
import vb_pkg::*;

module vb_accum (
   input  logic [31:0]             acc,
   input  logic [2:0]              idx,
   input  logic [VB_PAYLOAD_W-1:0] payload,
   output logic [31:0]             acc_next,
   output logic                    overflow
);

   always_comb begin
      acc_next = acc;
      case (idx)
         3'd0:    acc_next = acc | {25'b0, payload};
         3'd1:    acc_next = acc | {18'b0, payload, 7'b0};
         3'd2:    acc_next = acc | {11'b0, payload, 14'b0};
         3'd3:    acc_next = acc | {4'b0, payload, 21'b0};
         // only four bits of the last group fit in 32 bits
         3'd4:    acc_next = acc | {payload[3:0], 28'b0};
         default: acc_next = acc;
      endcase
   end

   assign overflow = (idx == 3'd4) && (payload[6:4] != 3'b000);

endmodule

// File: rtl/vb_decoder.sv
// rtl/vb_decoder.sv - variable-byte stream decoder top; VB_DEC_ERR_EN enables overflow/overlong checks
import vb_pkg::*;

module vb_decoder #(
   parameter int MAX_BYTES = VB_MAX_BYTES
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [7:0]  in_byte,
   output logic        in_ready,
   output logic        out_valid,
   output logic [31:0] out_data,
   output logic [2:0]  out_len,
   output logic        out_err,
   input  logic        out_ready
);

   localparam logic [1:0] ACCUM = VB_ACCUM;
   localparam logic [1:0] HOLD  = VB_HOLD;
`ifdef VB_DEC_ERR_EN
   localparam logic [1:0] DRAIN = VB_DRAIN;
`endif

   logic [1:0]  state;
   logic [2:0]  idx;
   logic [31:0] acc;
   logic [31:0] acc_next;
   logic        ovf;
   logic        accept;
   logic        cont;
   logic [2:0]  idx_inc;

   assign cont    = in_byte[VB_CONT_BIT];
   assign accept  = in_valid && in_ready;
   assign idx_inc = (idx == 3'(MAX_BYTES)) ? idx : idx + 3'd1;

   // in_ready depends on state alone, never on out_ready
   assign in_ready  = (state != HOLD);
   assign out_valid = (state == HOLD);
   assign out_data  = acc;
   assign out_len   = idx;

   vb_accum u_accum (
      .acc      (acc),
      .idx      (idx),
      .payload  (in_byte[VB_PAYLOAD_W-1:0]),
      .acc_next (acc_next),
      .overflow (ovf)
   );

`ifdef VB_DEC_ERR_EN
   logic err;
   assign out_err = err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ACCUM;
         idx   <= 3'd0;
         acc   <= 32'd0;
         err   <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  acc <= acc_next;
                  idx <= idx_inc;
                  if (cont && idx == 3'(MAX_BYTES - 1)) begin
                     // overlong word: discard payload and swallow the rest
                     state <= DRAIN;
                     acc   <= 32'd0;
                  end else if (!cont) begin
                     state <= HOLD;
                     err   <= ovf;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state <= ACCUM;
                  acc   <= 32'd0;
                  idx   <= 3'd0;
                  err   <= 1'b0;
               end
            end
            DRAIN: begin
               if (accept && !cont) begin
                  state <= HOLD;
                  err   <= 1'b1;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end
`else
   logic ovf_unused;
   assign ovf_unused = ovf;
   assign out_err    = 1'b0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ACCUM;
         idx   <= 3'd0;
         acc   <= 32'd0;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  acc <= acc_next;
                  idx <= idx_inc;
                  if (!cont) state <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state <= ACCUM;
                  acc   <= 32'd0;
                  idx   <= 3'd0;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_vb_decoder.sv
// tb/tb_vb_decoder.sv - randomized and directed bench for vb_decoder; follows VB_DEC_ERR_EN of the build
module tb_vb_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_byte = 8'h00;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic [2:0]  out_len;
   logic        out_err;
   logic        out_ready = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] word_q[$];

   vb_decoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_byte   (in_byte),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_len   (out_len),
      .out_err   (out_err),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
   endtask

   // Reference: value is the sum of the first five groups at 7-bit strides, cut to 32 bits
   task automatic model(output logic [31:0] d, output logic [2:0] l, output logic e);
      longint unsigned v;
      logic [7:0] b;
      int n;
      v = 0;
      n = word_q.size();
      for (int k = 0; k < n && k < 5; k++) begin
         b = word_q[k];
         v = v + (longint'(b & 8'h7f) << (7 * k));
      end
      d = v[31:0];
      l = (n > 5) ? 3'd5 : 3'(n);
      e = 1'b0;
`ifdef VB_DEC_ERR_EN
      if (n > 5) begin
         d = 32'd0;
         e = 1'b1;
      end else if (n == 5) begin
         b = word_q[4];
         if ((b >> 4) != 8'h00) e = 1'b1;
      end
`endif
   endtask

   task automatic send_byte(input logic [7:0] b, output int waited);
      in_byte  = b;
      in_valid = 1'b1;
      waited   = 0;
      while (!in_ready && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_word(input int max_gap);
      int w;
      for (int i = 0; i < word_q.size(); i++) begin
         if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
         send_byte(word_q[i], w);
      end
   endtask

   task automatic recv_word(input string tag, input int max_delay);
      logic [31:0] d;
      logic [2:0]  l;
      logic        e;
      int          n;
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      model(d, l, e);
      check({tag, "_data"}, out_data, d);
      check({tag, "_len"}, 32'(out_len), 32'(l));
      check({tag, "_err"}, 32'(out_err), 32'(e));
      if (max_delay > 0) repeat ($urandom_range(max_delay, 0)) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_bubble_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_bubble_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int w;
      int n;
      logic [7:0] b;

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_data", out_data, 32'd0);
      check("rst_len", 32'(out_len), 32'd0);
      check("rst_err", 32'(out_err), 32'd0);

      // Single zero byte: visible right after the accepting edge
      word_q = '{8'h00};
      send_word(0);
      check("zero_next_valid", 32'(out_valid), 32'd1);
      check("zero_next_ready", 32'(in_ready), 32'd0);
      recv_word("zero", 0);

      word_q = '{8'he5, 8'h8e, 8'h26};
      send_word(0);
      check("w624485_const", out_data, 32'h0009_8765);
      recv_word("w624485", 0);

      word_q = '{8'hff, 8'hff, 8'hff, 8'hff, 8'h0f};
      send_word(0);
      check("allones_const", out_data, 32'hffff_ffff);
      recv_word("allones", 0);

      // Backpressure: held word must not move and inputs are ignored
      word_q = '{8'hb3, 8'h41};
      send_word(0);
      in_valid = 1'b1;
      in_byte  = 8'h7f;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("bp_ready_low", 32'(in_ready), 32'd0);
         check("bp_data_stable", out_data, 32'h0000_20b3);
         check("bp_len_stable", 32'(out_len), 32'd2);
      end
      in_valid = 1'b0;
      recv_word("bp", 0);
      word_q = '{8'h12};
      send_byte(8'h12, w);
      check("bp_accept_latency", 32'(w), 32'd0);
      recv_word("bp_next", 0);

      // Reset mid-word drops the partial word
      send_byte(8'h81, w);
      send_byte(8'h81, w);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_ready", 32'(in_ready), 32'd1);
      word_q = '{8'h05};
      send_word(0);
      recv_word("midrst", 0);

      // Overflow and overlong streams (expectations follow the build)
      word_q = '{8'hff, 8'hff, 8'hff, 8'hff, 8'h1f};
      send_word(0);
      recv_word("ovf", 0);
      word_q = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01};
      send_word(0);
      recv_word("overlong", 0);

      // Reset while holding a word: it must not reappear
      word_q = '{8'h33};
      send_word(0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("holdrst_valid", 32'(out_valid), 32'd0);

      for (int t = 0; t < 300; t++) begin
         word_q.delete();
         n = $urandom_range(7, 1);
         for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            b[7] = (k != n - 1);
            if ($urandom_range(3, 0) == 0) b[6:0] = 7'h7f;
            word_q.push_back(b);
         end
         send_word(($urandom_range(1, 0) == 1) ? 2 : 0);
         recv_word("rnd", 3);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=%0d expected=finish", n_checks);
      $fatal(1);
   end

endmodule

// File: doc/vb_decoder.md
# vb_decoder

Variable-byte (VB) stream decoder: consumes the 8-bit VB byte stream produced by the VBEncoder stage and reassembles each encoded 32-bit unsigned integer. It sits directly downstream of the encoder in the lab datapath. Its output word is shown on the board LEDs and seven-segment display, or is fed back for encode/decode loop checks. Input and output both use valid/ready handshakes so the block can follow a stepped (button) clock or the divided board clock.

## Interface

Parameters:
- `MAX_BYTES`, 5: maximum bytes per encoded word (ceil(32/7)).

Ports:
- `clk`  in  1  block clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `in_valid`  in  1  `in_byte` holds a stream byte.
- `in_byte`  in  8  stream byte; bit7 = continuation (1 = more bytes follow), bits[6:0] = payload.
- `in_ready`  out  1  decoder accepts a byte this cycle.
- `out_valid`  out  1  `out_data` holds a decoded word.
- `out_data`  out  32  decoded integer.
- `out_len`  out  3  number of bytes consumed for this word (1..MAX_BYTES; saturates).
- `out_err`  out  1  word is malformed (see Configuration).
- `out_ready`  in  1  consumer takes the word.

## Operation

- Encoding is least-significant group first. Byte k (k = 0..4) carries payload bits [7k+6:7k]. A byte with bit7 = 0 terminates the word.
- FSM states:
  - ACCUM: `in_ready` = 1. On accept, insert the payload at group index `idx` and increment `idx` (saturating at MAX_BYTES).
    - Terminator accepted -> HOLD.
    - Overlong detected -> DRAIN (only when the macro is defined).
  - HOLD: `in_ready` = 0, `out_valid` = 1. On `out_valid & out_ready` -> ACCUM, with the accumulator, `idx` and the error flag cleared.
  - DRAIN: `in_ready` = 1. Accepted bytes are discarded. A terminator -> HOLD with `out_data` = 0 and `out_err` = 1.
- The accumulator is cleared at the start of each word, so a 1-byte word 0x05 yields 0x00000005.
- Group 4 contributes only bits [3:0] of its payload, mapped to data[31:28]. Payload bits [6:4] of byte 4 overflow.
- Reset values: state ACCUM, `in_ready` = 1 after reset release, `out_valid` = 0, `out_data` = 0, `out_len` = 0, `out_err` = 0, `idx` = 0.
- Reset asserted mid-word or in HOLD discards the partial or pending word; no output is produced for it.

## Timing

- A terminator accepted at edge N gives `out_valid` = 1 after edge N; combinational visibility is cycle N+1.
- `out_data`, `out_len` and `out_err` are registered and stable while `out_valid` = 1.
- Word handshake at edge M: `out_valid` = 0 and `in_ready` = 1 from cycle M+1. This is one bubble; the first byte of the next word is accepted at edge M+1 at the earliest.
- Throughput: an n-byte word takes n accept cycles plus 1 output cycle, with `out_ready` held high.
- `in_ready` is a function of state only; there is no combinational path from `out_ready` to `in_ready`.
- `in_valid` is ignored while `in_ready` = 0. The upstream stage must hold `in_byte` until accepted.

## Configuration

- `VB_DEC_ERR_EN` defined:
  - Overflow: byte 4 is a terminator with payload bits[6:4] != 0. The truncated word is emitted with `out_err` = 1.
  - Overlong: byte 4 has continuation = 1. The FSM enters DRAIN; the emitted word has `out_data` = 0, `out_len` = 5, `out_err` = 1.
- Macro undefined:
  - DRAIN state is not built and `out_err` is tied to 0.
  - Overflow bits are dropped silently.
  - Bytes beyond MAX_BYTES are accepted with payload ignored and `idx` saturated; the low 32 bits are emitted at the terminator.

## Structure

- Shared package `vb_pkg`: `VB_MAX_BYTES` = 5, `VB_CONT_BIT` = 7, `VB_PAYLOAD_W` = 7, the FSM state enum (ACCUM, HOLD, DRAIN). The VBEncoder uses the same constants.
- One sub-module, `vb_accum`: the payload-insert datapath (group index -> shifted OR into the 32-bit register, overflow detect). The FSM stays in `vb_decoder`.

## Test plan

- Reset, then byte 0x00 -> `out_valid` next cycle, `out_data` = 0x00000000, `out_len` = 1, `out_err` = 0.
- Bytes 0xE5, 0x8E, 0x26 back-to-back -> `out_data` = 0x00098765 (624485), `out_len` = 3.
- Bytes 0xFF, 0xFF, 0xFF, 0xFF, 0x0F -> `out_data` = 0xFFFFFFFF, `out_len` = 5, `out_err` = 0.
- Backpressure: `out_ready` = 0 for 4 cycles after a word -> `in_ready` stays 0 and `out_data` stays stable. Release -> next word's first byte accepted one cycle after the handshake.
- Reset pulse after 0x81, 0x81, then 0x05 -> `out_data` = 0x00000005, `out_len` = 1 (the partial word is discarded).
- With `VB_DEC_ERR_EN`, stream 0xFF ×4, 0x1F -> `out_data` = 0xFFFFFFFF, `out_err` = 1. Stream 0x80 ×5, 0x80, 0x01 -> a single word, `out_data` = 0, `out_err` = 1. Without the macro, the same second stream -> `out_data` = 0, `out_err` = 0.
